// File: rtl/shared_reg_pkg.sv
// Purpose: shared types and constants for the two-requester shared register arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shared_reg_pkg;

  // Encoding chosen so the state register bits are the one-hot grant itself:
  // IDLE=00, G0=01, G1=10. gnt is then a direct flop output.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  // Requester index constants into req/wr/gnt.
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/d_flip_flop.sv
// Purpose: single edge-triggered D flip-flop cell with asynchronous reset value.
// Latency: d captured on rising clk edge, visible after that edge.
// Backpressure: none; loads every cycle (load gating is done by the caller's mux).
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; forces q to RESET_VAL
//   d     - next value
//   q     - registered value
module d_flip_flop #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/shared_reg.sv
// Purpose: WIDTH-bit enabled storage register with a two-way data select, built from d_flip_flop cells.
// Latency: selected data visible in q one cycle after en is sampled high.
// Backpressure: none; en low simply recirculates q.
//
// Ports:
//   clk, reset    - clock and asynchronous active-high reset (q <- RESET_VAL)
//   en            - load enable for this cycle
//   sel           - 0 selects data0, 1 selects data1
//   data0, data1  - candidate write data
//   q             - register contents
module shared_reg #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sel,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] d;

  assign wdata = sel ? data1 : data0;
  // Load mux: hold the current contents unless a write is enabled.
  assign d     = en ? wdata : q;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    d_flip_flop #(
      .RESET_VAL(RESET_VAL[i])
    ) u_dff (
      .clk  (clk),
      .reset(reset),
      .d    (d[i]),
      .q    (q[i])
    );
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Purpose: round-robin arbiter granting one of two writers exclusive, time-bounded access to a shared register.
// Latency: req -> gnt 1 cycle; granted wr/data -> q 1 cycle; release and next grant in the same cycle.
// Backpressure: a waiting requester holds req until granted; a grant is forcibly released after MAX_HOLD cycles.
//
// Ports:
//   clk, reset    - clock and asynchronous active-high reset
//   req[1:0]      - per-requester access request
//   wr[1:0]       - per-requester write strobe, honoured only for the granted requester
//   data0, data1  - write data from requester 0 / 1
//   gnt[1:0]      - registered one-hot grant, 00 when idle
//   q             - shared register contents
//   busy          - registered, high whenever gnt != 00
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       MAX_HOLD  = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       wr,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  localparam int unsigned     CW       = $clog2(MAX_HOLD + 1);
  // cnt counts completed cycles of the current grant minus one: it reads 0 in
  // the first granted cycle, so CNT_LAST marks the MAX_HOLD-th granted cycle.
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(MAX_HOLD);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;   // requester most recently granted
  logic            busy_q;
  logic            wr_en;
  logic            wr_sel;

  // Next-state, hold counter and round-robin pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Requester 0 wins if alone, or on contention when 1 was served last.
        if (req[REQ0] && (!req[REQ1] || last_q)) begin
          state_d = G0;
          last_d  = 1'b0;
        end else if (req[REQ1]) begin
          state_d = G1;
          last_d  = 1'b1;
        end
      end

      G0: begin
        if (!req[REQ0] || (cnt_q == CNT_LAST)) begin
          cnt_d = '0;
          if (req[REQ1]) begin
            state_d = G1;
            last_d  = 1'b1;
          end else if (req[REQ0]) begin
            // Timed out with nobody else waiting: fresh grant, counter cleared.
            state_d = G0;
            last_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
      end

      G1: begin
        if (!req[REQ1] || (cnt_q == CNT_LAST)) begin
          cnt_d = '0;
          if (req[REQ0]) begin
            state_d = G0;
            last_d  = 1'b0;
          end else if (req[REQ1]) begin
            state_d = G1;
            last_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      // Registered separately so busy is a flop output rather than an OR of gnt.
      busy_q  <= (state_d != IDLE);
    end
  end

  // Write path is driven from the current state, so the release cycle still writes.
  assign wr_en  = ((state_q == G0) && wr[REQ0]) || ((state_q == G1) && wr[REQ1]);
  assign wr_sel = (state_q == G1);

  shared_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_reg (
    .clk  (clk),
    .reset(reset),
    .en   (wr_en),
    .sel  (wr_sel),
    .data0(data0),
    .data1(data1),
    .q    (q)
  );

  assign gnt  = state_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Purpose: directed self-checking bench for shared_reg_arbiter (MAX_HOLD=4 main instance, MAX_HOLD=1 side instance).
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next rising edge.
// Backpressure: n/a.
module tb_shared_reg_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] wr;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [1:0] gnt;
  logic [7:0] q;
  logic       busy;
  logic [1:0] gnt1;
  logic [7:0] q1;
  logic       busy1;

  int n_chk  = 0;
  int n_pass = 0;

  shared_reg_arbiter #(.WIDTH(8), .MAX_HOLD(4), .RESET_VAL(8'h00)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .wr   (wr),
    .data0(data0),
    .data1(data1),
    .gnt  (gnt),
    .q    (q),
    .busy (busy)
  );

  shared_reg_arbiter #(.WIDTH(8), .MAX_HOLD(1), .RESET_VAL(8'h00)) dut1 (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .wr   (wr),
    .data0(data0),
    .data1(data1),
    .gnt  (gnt1),
    .q    (q1),
    .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    wr    = 2'b00;
    data0 = 8'h00;
    data1 = 8'h00;
    tick();
    tick();
    chk("rst_gnt",   32'(gnt),   32'h0);
    chk("rst_busy",  32'(busy),  32'h0);
    chk("rst_q",     32'(q),     32'h00);
    chk("rst_q_mh1", 32'(q1),    32'h00);
    reset = 1'b0;

    // Reset mid-grant: write A5 lands on the second edge, then async reset clears it.
    req = 2'b01; wr = 2'b01; data0 = 8'hA5;
    tick();
    chk("mid_gnt_e1", 32'(gnt), 32'h1);
    chk("mid_q_e1",   32'(q),   32'h00);  // write ignored while still IDLE
    tick();
    chk("mid_q_e2",   32'(q),   32'hA5);
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt",  32'(gnt),  32'h0);
    chk("mid_rst_q",    32'(q),    32'h00);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    req = 2'b00; wr = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_q",   32'(q),   32'h00);
    chk("post_rst_gnt", 32'(gnt), 32'h0);

    // Contention from IDLE: requester 0 wins first, handover with no idle gap.
    req = 2'b11;
    tick();
    chk("cont_gnt0",  32'(gnt),  32'h1);
    chk("cont_busy",  32'(busy), 32'h1);
    chk("cont_gnt0_mh1", 32'(gnt1), 32'h1);
    req = 2'b10;
    tick();
    chk("cont_gnt1", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    chk("cont_idle",      32'(gnt),  32'h0);
    chk("cont_idle_busy", 32'(busy), 32'h0);

    // Timeout: last served was 1, so 0 goes first; 01x4, 10x4, 01x4.
    // MAX_HOLD=1 instance alternates every cycle starting with 01.
    req = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      logic [1:0] e;
      logic [1:0] e1;
      tick();
      e  = (((k - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      e1 = (k % 2 == 1) ? 2'b01 : 2'b10;
      chk($sformatf("to_gnt_%0d", k),      32'(gnt),   32'(e));
      chk($sformatf("to_busy_%0d", k),     32'(busy),  32'h1);
      chk($sformatf("to_gnt_mh1_%0d", k),  32'(gnt1),  32'(e1));
      chk($sformatf("to_busy_mh1_%0d", k), 32'(busy1), 32'h1);
    end
    req = 2'b00;
    tick();
    chk("to_idle", 32'(gnt), 32'h0);

    // Write filtering: ungranted strobe ignored, granted strobe lands.
    req = 2'b01;
    tick();
    chk("wf_gnt", 32'(gnt), 32'h1);
    wr = 2'b10; data1 = 8'h3C; data0 = 8'h11;
    tick();
    chk("wf_q_ignored", 32'(q), 32'h00);
    wr = 2'b01; data0 = 8'h5A;
    tick();
    chk("wf_q_written", 32'(q),   32'h5A);
    chk("wf_gnt_held",  32'(gnt), 32'h1);

    // Write on the release cycle.
    req = 2'b00; wr = 2'b01; data0 = 8'hF0;
    tick();
    chk("rel_q",   32'(q),   32'hF0);
    chk("rel_gnt", 32'(gnt), 32'h0);
    // Strobe in IDLE is ignored.
    data0 = 8'h77;
    tick();
    chk("idle_wr_q", 32'(q), 32'hF0);

    // Solo timeout: grant re-enters without a gap; every write after the first edge lands.
    req = 2'b01; wr = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      logic [7:0] exp_q;
      data0 = 8'(k * 8'h11);
      tick();
      exp_q = (k == 1) ? 8'hF0 : 8'(k * 8'h11);
      chk($sformatf("solo_gnt_%0d", k), 32'(gnt), 32'h1);
      chk($sformatf("solo_q_%0d", k),   32'(q),   32'(exp_q));
    end
    req = 2'b00; wr = 2'b00;
    tick();
    chk("solo_end_gnt",  32'(gnt),  32'h0);
    chk("solo_end_busy", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Two-requester round-robin arbiter that shares one WIDTH-bit storage register, built from our edge-triggered D flip-flop cells, between two writers. It grants exclusive write access to one requester at a time, bounds how long a grant is held, and latches the granted requester's data on its write strobe. It sits between the switch/FSM front ends and the LEDR display register on the board top level.

## Interface
- WIDTH, 8, width of the shared register and both data inputs
- MAX_HOLD, 4, maximum consecutive cycles one grant may be held (≥1)
- RESET_VAL, 0, value loaded into the register on reset
- clk  in  1  system clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- req  in  2  req[i] requests the register for requester i
- wr  in  2  wr[i] write strobe from requester i; honoured only while gnt[i]=1
- data0  in  WIDTH  write data from requester 0
- data1  in  WIDTH  write data from requester 1
- gnt  out  2  one-hot grant (registered), 00 when idle
- q  out  WIDTH  shared register contents
- busy  out  1  high whenever gnt≠00

## Operation
- FSM states: IDLE, G0, G1; gnt = {state==G1, state==G0}; busy = |gnt.
- last_served flag (1 bit) records the requester most recently granted; reset value 1, so requester 0 wins the first contention.
- IDLE: req=01 → G0; req=10 → G1; req=11 → grant the requester ≠ last_served; req=00 → stay.
- Gi: hold counter increments each cycle; release when req[i] sampled low, or when the counter shows the grant has been held MAX_HOLD cycles.
- On release from Gi: if req[other]=1 → G_other directly (no idle cycle); else if req[i]=1 (timeout case) → re-enter Gi with counter cleared; else → IDLE. last_served updated to i on every entry to Gi.
- Write: at a rising edge with state Gi and wr[i]=1, q ← data_i. This includes the release cycle. wr from the ungranted requester is ignored; wr in IDLE is ignored.
- Counter width $clog2(MAX_HOLD+1); counter cleared on every grant entry and in IDLE; never wraps.
- Reset (any time, including mid-grant): state IDLE, gnt=00, busy=0, q=RESET_VAL, counter=0, last_served=1. Writes pending at reset are discarded.

## Timing
- Grant latency: req sampled at edge N → gnt visible after edge N (one cycle from request to grant).
- Write latency: wr/data sampled at edge N while granted → q updated after edge N.
- Release latency: req[i] low at edge N → gnt[i] low after edge N; the next grant, if any, is visible in the same cycle (back-to-back handover).
- Timeout: with req[i] held high and the other requester waiting, gnt[i] stays high for exactly MAX_HOLD cycles, then gnt switches.
- MAX_HOLD=1: grants alternate every cycle under continuous contention.
- Outputs glitch-free: gnt, busy, q come directly from flip-flops.

## Structure
- Package shared_reg_pkg: state enum (IDLE, G0, G1), REQ0/REQ1 index constants.
- Sub-module shared_reg: WIDTH-bit enabled register (instances of d_flip_flop with load mux, asynchronous reset to RESET_VAL). The arbiter drives its enable and data-select signals.
- Arbiter FSM, counter and last_served live in shared_reg_arbiter.

## Test plan
- Reset mid-grant: req=01, wr0=1, data0=8'hA5 for 2 cycles, then pulse reset → gnt=00, q=8'h00 immediately, no write observed after reset release.
- Contention from IDLE after reset: req=11 in one cycle → gnt=01 next cycle; drop req0 → gnt=10 the following cycle, no IDLE gap.
- Timeout, MAX_HOLD=4: req=11 continuously → gnt pattern 01×4, 10×4, 01×4; busy high throughout.
- Write filtering: gnt=01, wr=10 with data1=8'h3C → q unchanged; wr=01 with data0=8'h5A → q=8'h5A one cycle later.
- Write on release cycle: gnt=01, in same cycle req0=0, wr0=1, data0=8'hF0 → q=8'hF0 and gnt=00 after that edge.
- Solo timeout: req=01 held 10 cycles with MAX_HOLD=4 → gnt stays 01 continuously (re-grant), every wr0 lands in q.
